// File: rtl/command_processor_pkg.sv
// Shared types and encodings for the command-buffer processor.
package command_processor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_FETCH,
    DECODE,
    DISPATCH,
    WAIT_UNIT,
    DONE,
    ERROR
  } cmdState_t;

  localparam logic [3:0] OP_END      = 4'd0;
  localparam logic [3:0] OP_DISPATCH = 4'd1;
  localparam logic [3:0] OP_NOP      = 4'd2;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_UNIT = 2'd1;
  localparam logic [1:0] ERR_MAX_CMDS = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

endpackage

// File: rtl/command_processor_decoder.sv
// Field extraction and unit-range check on the top byte of the command register.
module command_decoder
  import command_processor_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 4
) (
  input  logic [7:0] aCommandHead,
  output logic       is_end,
  output logic       is_dispatch,
  output logic [3:0] unit_idx,
  output logic       bad_unit
);

  logic [3:0] opcode;

  assign opcode      = aCommandHead[7:4];
  assign unit_idx    = aCommandHead[3:0];
  assign is_end      = (opcode == OP_END);
  assign is_dispatch = (opcode == OP_DISPATCH);
  assign bad_unit    = is_dispatch && (32'(unit_idx) >= NUM_UNITS);

endmodule

// File: rtl/command_processor.sv
// Walks a command buffer, dispatching words to execution units one at a time.
// Optional fetch watchdog enabled by defining CMDPROC_TIMEOUT_EN.
module command_processor
  import command_processor_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned ADDR_STRIDE    = 4,
  parameter int unsigned MAX_CMDS       = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned CNT_W         = $clog2(MAX_CMDS + 1)
) (
  input  logic                 aClock,
  input  logic                 aReset,
  input  logic                 anExecute,
  input  logic [ADDR_W-1:0]    aCommandBufferAddress,
  output logic [ADDR_W-1:0]    anOutMemoryAddr,
  output logic                 anOutMemoryEnable,
  input  logic [DATA_W-1:0]    aMemoryData,
  input  logic                 aMemoryValid,
  output logic [NUM_UNITS-1:0] anOutUnitStart,
  output logic [DATA_W-1:0]    anOutCommandWord,
  input  logic [NUM_UNITS-1:0] aUnitDone,
  output logic                 anOutBusy,
  output logic                 anOutDone,
  output logic                 anOutError,
  output logic [1:0]           anOutErrorCode,
  output logic [CNT_W-1:0]     anOutCommandCount
);

  if (DATA_W < 16 || NUM_UNITS < 1 || NUM_UNITS > 16 || TIMEOUT_CYCLES < 1) begin : gParamCheck
    $error("command_processor: parameter out of range");
  end

  cmdState_t            state;
  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    cmdReg;
  logic [NUM_UNITS-1:0] unitMask;
  logic                 isEnd;
  logic                 isDispatch;
  logic [3:0]           unitIdx;
  logic                 badUnit;
  logic [ADDR_W-1:0]    nextAddr;
  logic                 unitHit;

`ifdef CMDPROC_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] fetchTimer;
`endif

  command_decoder #(.NUM_UNITS(NUM_UNITS)) uDecoder (
    .aCommandHead (cmdReg[DATA_W-1 -: 8]),
    .is_end       (isEnd),
    .is_dispatch  (isDispatch),
    .unit_idx     (unitIdx),
    .bad_unit     (badUnit)
  );

  // Address wraps naturally at 2^ADDR_W.
  assign nextAddr = addr + ADDR_W'(ADDR_STRIDE);
  assign unitHit  = |(aUnitDone & unitMask);

  // Outputs are set on entry to the state that owns them, so they are all registered.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      state             <= IDLE;
      addr              <= '0;
      cmdReg            <= '0;
      unitMask          <= '0;
      anOutMemoryAddr   <= '0;
      anOutMemoryEnable <= 1'b0;
      anOutUnitStart    <= '0;
      anOutCommandWord  <= '0;
      anOutBusy         <= 1'b0;
      anOutDone         <= 1'b0;
      anOutError        <= 1'b0;
      anOutErrorCode    <= ERR_NONE;
      anOutCommandCount <= '0;
`ifdef CMDPROC_TIMEOUT_EN
      fetchTimer        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (anExecute) begin
            addr              <= aCommandBufferAddress;
            anOutMemoryAddr   <= aCommandBufferAddress;
            anOutMemoryEnable <= 1'b1;
            anOutBusy         <= 1'b1;
            anOutError        <= 1'b0;
            anOutErrorCode    <= ERR_NONE;
            anOutCommandCount <= '0;
            state             <= FETCH;
          end
        end
        FETCH: begin
          anOutMemoryEnable <= 1'b0;
`ifdef CMDPROC_TIMEOUT_EN
          fetchTimer        <= '0;
`endif
          state             <= WAIT_FETCH;
        end
        WAIT_FETCH: begin
          if (aMemoryValid) begin
            cmdReg <= aMemoryData;
            state  <= DECODE;
          end
`ifdef CMDPROC_TIMEOUT_EN
          else if (fetchTimer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            anOutError     <= 1'b1;
            anOutErrorCode <= ERR_TIMEOUT;
            state          <= ERROR;
          end else begin
            fetchTimer <= fetchTimer + TMR_W'(1);
          end
`endif
        end
        DECODE: begin
          if (isEnd) begin
            anOutDone <= 1'b1;
            state     <= DONE;
          end else if (anOutCommandCount == CNT_W'(MAX_CMDS)) begin
            anOutError     <= 1'b1;
            anOutErrorCode <= ERR_MAX_CMDS;
            state          <= ERROR;
          end else if (badUnit) begin
            anOutError     <= 1'b1;
            anOutErrorCode <= ERR_BAD_UNIT;
            state          <= ERROR;
          end else if (isDispatch) begin
            unitMask         <= NUM_UNITS'(1) << unitIdx;
            anOutUnitStart   <= NUM_UNITS'(1) << unitIdx;
            anOutCommandWord <= cmdReg;
            state            <= DISPATCH;
          end else begin
            anOutCommandCount <= anOutCommandCount + CNT_W'(1);
            addr              <= nextAddr;
            anOutMemoryAddr   <= nextAddr;
            anOutMemoryEnable <= 1'b1;
            state             <= FETCH;
          end
        end
        DISPATCH: begin
          anOutUnitStart <= '0;
          state          <= WAIT_UNIT;
        end
        WAIT_UNIT: begin
          if (unitHit) begin
            anOutCommandWord  <= '0;
            anOutCommandCount <= anOutCommandCount + CNT_W'(1);
            addr              <= nextAddr;
            anOutMemoryAddr   <= nextAddr;
            anOutMemoryEnable <= 1'b1;
            state             <= FETCH;
          end
        end
        DONE: begin
          anOutDone <= 1'b0;
          anOutBusy <= 1'b0;
          state     <= IDLE;
        end
        ERROR: begin
          anOutBusy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_command_processor.sv
// Directed self-checking bench for command_processor (honours CMDPROC_TIMEOUT_EN).
module tb_command_processor;

  localparam int unsigned CNT_W = 9;

  logic        aClock;
  logic        aReset;
  logic        anExecute;
  logic [31:0] aCommandBufferAddress;
  logic [31:0] anOutMemoryAddr;
  logic        anOutMemoryEnable;
  logic [31:0] aMemoryData;
  logic        aMemoryValid;
  logic [3:0]  anOutUnitStart;
  logic [31:0] anOutCommandWord;
  logic [3:0]  aUnitDone;
  logic        anOutBusy;
  logic        anOutDone;
  logic        anOutError;
  logic [1:0]  anOutErrorCode;
  logic [CNT_W-1:0] anOutCommandCount;

  logic [3:0]  respDone;
  logic [3:0]  manualDone;
  logic        memRespEn;
  logic        unitRespEn;
  logic [31:0] mem [0:511];
  logic [31:0] fetchLog [$];
  logic [3:0]  startLog [$];
  int          doneCnt;
  int          nCompared;
  int          nMismatched;

  assign aUnitDone = respDone | manualDone;

  command_processor #(
    .ADDR_W(32), .DATA_W(32), .NUM_UNITS(4), .ADDR_STRIDE(4),
    .MAX_CMDS(256), .TIMEOUT_CYCLES(16)
  ) dut (
    .aClock                (aClock),
    .aReset                (aReset),
    .anExecute             (anExecute),
    .aCommandBufferAddress (aCommandBufferAddress),
    .anOutMemoryAddr       (anOutMemoryAddr),
    .anOutMemoryEnable     (anOutMemoryEnable),
    .aMemoryData           (aMemoryData),
    .aMemoryValid          (aMemoryValid),
    .anOutUnitStart        (anOutUnitStart),
    .anOutCommandWord      (anOutCommandWord),
    .aUnitDone             (aUnitDone),
    .anOutBusy             (anOutBusy),
    .anOutDone             (anOutDone),
    .anOutError            (anOutError),
    .anOutErrorCode        (anOutErrorCode),
    .anOutCommandCount     (anOutCommandCount)
  );

  initial aClock = 1'b0;
  always #5 aClock = ~aClock;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'h1000) >> 2;
    if (off < 32'd512) return mem[off[8:0]];
    return 32'h0;
  endfunction

  // Memory model: word appears two cycles after the fetch strobe.
  initial begin
    logic [31:0] a;
    aMemoryValid = 1'b0;
    aMemoryData  = '0;
    forever begin
      @(negedge aClock);
      if (memRespEn && anOutMemoryEnable) begin
        a = anOutMemoryAddr;
        @(negedge aClock);
        @(negedge aClock);
        aMemoryData  = memWord(a);
        aMemoryValid = 1'b1;
        @(negedge aClock);
        aMemoryValid = 1'b0;
      end
    end
  end

  // Unit model: completion pulse five cycles after the start strobe.
  initial begin
    logic [3:0] s;
    respDone = '0;
    forever begin
      @(negedge aClock);
      if (unitRespEn && anOutUnitStart != 4'b0) begin
        s = anOutUnitStart;
        repeat (5) @(negedge aClock);
        respDone = s;
        @(negedge aClock);
        respDone = '0;
      end
    end
  end

  initial begin
    doneCnt = 0;
    forever begin
      @(negedge aClock);
      if (anOutMemoryEnable) fetchLog.push_back(anOutMemoryAddr);
      if (anOutUnitStart != 4'b0) startLog.push_back(anOutUnitStart);
      if (anOutDone) doneCnt++;
    end
  end

  task automatic clearLogs();
    fetchLog.delete();
    startLog.delete();
    doneCnt = 0;
  endtask

  task automatic startRun(input logic [31:0] a);
    @(negedge aClock);
    aCommandBufferAddress = a;
    anExecute = 1'b1;
    @(negedge aClock);
    anExecute = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n;
    n = 0;
    while (anOutBusy && n < budget) begin
      @(negedge aClock);
      n++;
    end
    nCompared++;
    if (anOutBusy !== 1'b0) begin
      nMismatched++;
      $display("FAIL %s idle-timeout: busy=%b after %0d cycles, required 0", tag, anOutBusy, n);
    end
  endtask

  task automatic test_reset();
    @(negedge aClock);
    nCompared++;
    if ({anOutMemoryAddr, anOutMemoryEnable, anOutUnitStart, anOutCommandWord, anOutBusy,
         anOutDone, anOutError, anOutErrorCode, anOutCommandCount} !== '0) begin
      nMismatched++;
      $display("FAIL reset-outputs: addr=%h en=%b start=%b word=%h busy=%b done=%b err=%b code=%0d cnt=%0d, required all 0",
               anOutMemoryAddr, anOutMemoryEnable, anOutUnitStart, anOutCommandWord, anOutBusy,
               anOutDone, anOutError, anOutErrorCode, anOutCommandCount);
    end
  endtask

  task automatic test_dispatch();
    logic [31:0] expAddr [3];
    logic [3:0]  expStart [2];
    expAddr = '{32'h1000, 32'h1004, 32'h1008};
    expStart = '{4'b0010, 4'b1000};
    mem[0] = 32'h1100_0000;
    mem[1] = 32'h1300_0000;
    mem[2] = 32'h0000_0000;
    clearLogs();
    startRun(32'h1000);
    waitIdle(200, "dispatch");
    nCompared++;
    if (fetchLog.size() != 3) begin
      nMismatched++;
      $display("FAIL dispatch-fetch-count: got %0d, required 3", fetchLog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nCompared++;
        if (fetchLog[i] !== expAddr[i]) begin
          nMismatched++;
          $display("FAIL dispatch-fetch-addr[%0d]: got %h, required %h", i, fetchLog[i], expAddr[i]);
        end
      end
    end
    nCompared++;
    if (startLog.size() != 2) begin
      nMismatched++;
      $display("FAIL dispatch-start-count: got %0d, required 2", startLog.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        nCompared++;
        if (startLog[i] !== expStart[i]) begin
          nMismatched++;
          $display("FAIL dispatch-start[%0d]: got %b, required %b", i, startLog[i], expStart[i]);
        end
      end
    end
    nCompared++;
    if (doneCnt != 1) begin
      nMismatched++;
      $display("FAIL dispatch-done-pulses: got %0d, required 1", doneCnt);
    end
    nCompared++;
    if (anOutCommandCount !== CNT_W'(2) || anOutError !== 1'b0) begin
      nMismatched++;
      $display("FAIL dispatch-count-err: count=%0d err=%b, required 2 and 0", anOutCommandCount, anOutError);
    end
  endtask

  task automatic test_bad_unit();
    mem[0] = 32'h1500_0000;
    clearLogs();
    startRun(32'h1000);
    waitIdle(100, "bad-unit");
    nCompared++;
    if (anOutError !== 1'b1 || anOutErrorCode !== 2'd1) begin
      nMismatched++;
      $display("FAIL bad-unit-error: err=%b code=%0d, required 1 and 1", anOutError, anOutErrorCode);
    end
    nCompared++;
    if (startLog.size() != 0 || doneCnt != 0) begin
      nMismatched++;
      $display("FAIL bad-unit-pulses: starts=%0d dones=%0d, required 0 and 0", startLog.size(), doneCnt);
    end
    nCompared++;
    if (anOutCommandCount !== CNT_W'(0)) begin
      nMismatched++;
      $display("FAIL bad-unit-count: got %0d, required 0", anOutCommandCount);
    end
  endtask

  task automatic test_nop();
    mem[0] = 32'h2000_0000;
    mem[1] = 32'h2000_0000;
    mem[2] = 32'h0000_0000;
    clearLogs();
    startRun(32'h1000);
    nCompared++;
    if (anOutError !== 1'b0 || anOutErrorCode !== 2'd0 || anOutBusy !== 1'b1) begin
      nMismatched++;
      $display("FAIL nop-start-clears-error: err=%b code=%0d busy=%b, required 0 0 1",
               anOutError, anOutErrorCode, anOutBusy);
    end
    waitIdle(200, "nop");
    nCompared++;
    if (anOutCommandCount !== CNT_W'(2) || startLog.size() != 0 || doneCnt != 1) begin
      nMismatched++;
      $display("FAIL nop-result: count=%0d starts=%0d dones=%0d, required 2 0 1",
               anOutCommandCount, startLog.size(), doneCnt);
    end
  endtask

  task automatic test_max_cmds();
    for (int i = 0; i < 257; i++) mem[i] = 32'h2000_0000;
    mem[257] = 32'h0000_0000;
    clearLogs();
    startRun(32'h1000);
    waitIdle(3000, "max-cmds");
    nCompared++;
    if (anOutError !== 1'b1 || anOutErrorCode !== 2'd2) begin
      nMismatched++;
      $display("FAIL max-cmds-error: err=%b code=%0d, required 1 and 2", anOutError, anOutErrorCode);
    end
    nCompared++;
    if (anOutCommandCount !== CNT_W'(256) || fetchLog.size() != 257 || doneCnt != 0) begin
      nMismatched++;
      $display("FAIL max-cmds-count: count=%0d fetches=%0d dones=%0d, required 256 257 0",
               anOutCommandCount, fetchLog.size(), doneCnt);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    mem[0] = 32'h1200_0000;
    mem[1] = 32'h0000_0000;
    unitRespEn = 1'b0;
    clearLogs();
    startRun(32'h1000);
    n = 0;
    while (startLog.size() == 0 && n < 30) begin
      @(negedge aClock);
      n++;
    end
    nCompared++;
    if (startLog.size() != 1 || startLog[0] !== 4'b0100) begin
      nMismatched++;
      $display("FAIL other-done-start: starts=%0d, required one 0100 strobe", startLog.size());
    end
    manualDone = 4'b0001;
    @(negedge aClock);
    manualDone = 4'b0000;
    anExecute = 1'b1;
    @(negedge aClock);
    anExecute = 1'b0;
    repeat (3) @(negedge aClock);
    nCompared++;
    if (anOutBusy !== 1'b1 || fetchLog.size() != 1 || anOutCommandWord !== 32'h1200_0000) begin
      nMismatched++;
      $display("FAIL other-done-ignored: busy=%b fetches=%0d word=%h, required 1 1 12000000",
               anOutBusy, fetchLog.size(), anOutCommandWord);
    end
    manualDone = 4'b0100;
    @(negedge aClock);
    manualDone = 4'b0000;
    waitIdle(100, "own-done");
    nCompared++;
    if (fetchLog.size() != 2 || anOutCommandCount !== CNT_W'(1) || doneCnt != 1 || startLog.size() != 1) begin
      nMismatched++;
      $display("FAIL own-done-result: fetches=%0d count=%0d dones=%0d starts=%0d, required 2 1 1 1",
               fetchLog.size(), anOutCommandCount, doneCnt, startLog.size());
    end
    unitRespEn = 1'b1;
  endtask

  task automatic test_timeout_reset();
    int n;
    memRespEn = 1'b0;
    clearLogs();
    startRun(32'h1000);
`ifdef CMDPROC_TIMEOUT_EN
    n = 0;
    while (!anOutError && n < 40) begin
      @(negedge aClock);
      n++;
    end
    nCompared++;
    if (anOutError !== 1'b1 || anOutErrorCode !== 2'd3 || n != 17) begin
      nMismatched++;
      $display("FAIL timeout-code: err=%b code=%0d seen after %0d cycles, required 1 3 17",
               anOutError, anOutErrorCode, n);
    end
`else
    repeat (40) @(negedge aClock);
    nCompared++;
    if (anOutBusy !== 1'b1 || anOutError !== 1'b0 || fetchLog.size() != 1) begin
      nMismatched++;
      $display("FAIL no-timeout-wait: busy=%b err=%b fetches=%0d, required 1 0 1",
               anOutBusy, anOutError, fetchLog.size());
    end
`endif
    aReset = 1'b1;
    @(negedge aClock);
    aReset = 1'b0;
    memRespEn = 1'b1;
    unitRespEn = 1'b0;
    mem[0] = 32'h1100_0000;
    clearLogs();
    startRun(32'h1000);
    n = 0;
    while (startLog.size() == 0 && n < 30) begin
      @(negedge aClock);
      n++;
    end
    repeat (2) @(negedge aClock);
    nCompared++;
    if (anOutBusy !== 1'b1 || anOutCommandWord !== 32'h1100_0000) begin
      nMismatched++;
      $display("FAIL pre-reset-wait-unit: busy=%b word=%h, required 1 11000000", anOutBusy, anOutCommandWord);
    end
    aReset = 1'b1;
    #1;
    nCompared++;
    if ({anOutMemoryAddr, anOutMemoryEnable, anOutUnitStart, anOutCommandWord, anOutBusy,
         anOutDone, anOutError, anOutErrorCode, anOutCommandCount} !== '0) begin
      nMismatched++;
      $display("FAIL async-reset-outputs: busy=%b word=%h addr=%h cnt=%0d, required all 0",
               anOutBusy, anOutCommandWord, anOutMemoryAddr, anOutCommandCount);
    end
    @(negedge aClock);
    aReset = 1'b0;
    manualDone = 4'b0010;
    @(negedge aClock);
    manualDone = 4'b0000;
    repeat (4) @(negedge aClock);
    nCompared++;
    if (anOutBusy !== 1'b0 || fetchLog.size() != 1 || anOutMemoryEnable !== 1'b0) begin
      nMismatched++;
      $display("FAIL late-done-ignored: busy=%b fetches=%0d en=%b, required 0 1 0",
               anOutBusy, fetchLog.size(), anOutMemoryEnable);
    end
    unitRespEn = 1'b1;
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    aReset = 1'b1;
    anExecute = 1'b0;
    aCommandBufferAddress = '0;
    manualDone = '0;
    memRespEn = 1'b1;
    unitRespEn = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    repeat (3) @(negedge aClock);
    test_reset();
    aReset = 1'b0;
    test_dispatch();
    test_bad_unit();
    test_nop();
    test_max_cmds();
    test_back_to_back();
    test_timeout_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
